// File: rtl/alu_exec_ctrl.sv
// Execute stage around the combinational ALU: accepts a load or ALU request,
// owns the accumulator and flag register, and hands the result downstream.
module alu_exec_ctrl #(
    parameter int WIDTH   = 16,
    parameter int OP_W    = 4,
    parameter int NUM_OPS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_load,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_operand,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH:0]   alu_res,
    input  logic [1:0]       alu_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_flag,
    output logic             out_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [OP_W:0] LP_NUM_OPS = NUM_OPS[OP_W:0];

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_b;
    logic [OP_W-1:0]  r_op;
    logic [1:0]       r_flags;
    logic             r_err;
    logic             r_live;
    logic             w_accept;
    logic             w_illegal;
    logic             w_unused_carry;

    // Carry is taken from alu_flag[1]; the result MSB is informational only.
    assign w_unused_carry = alu_res[WIDTH];

    // r_live keeps in_ready low until the first clock edge after reset release.
    assign in_ready  = r_live && (r_state == S_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign w_illegal = ({1'b0, in_op} >= LP_NUM_OPS);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (in_load || w_illegal) ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: w_next = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_flags <= '0;
            r_err   <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                if (in_load) begin
                    r_acc <= in_operand;
                    r_err <= 1'b0;
                end else if (w_illegal) begin
                    r_err <= 1'b1;
                end else begin
                    r_b   <= in_operand;
                    r_op  <= in_op;
                    r_err <= 1'b0;
                end
            end
            if (r_state == S_EXEC) begin
                r_acc   <= alu_res[WIDTH-1:0];
                r_flags <= alu_flag;
            end
        end
    end

    assign alu_a     = r_acc;
    assign alu_b     = r_b;
    assign alu_op    = r_op;
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_acc;
    assign out_flag  = r_flags;
    assign out_err   = r_err;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: transaction-level model checked every cycle,
// directed literal scenarios, then randomized traffic.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_load = 1'b0;
    logic [3:0]  in_op = '0;
    logic [15:0] in_operand = '0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [16:0] alu_res;
    logic [1:0]  alu_flag;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  out_flag;
    logic        out_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.WIDTH(16), .OP_W(4), .NUM_OPS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
        .in_op(in_op), .in_operand(in_operand),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_flag(alu_flag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flag(out_flag), .out_err(out_err)
    );

    // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a, 7 SHR a.
    function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
        case (op)
            4'd0: return {1'b0, a} + {1'b0, b};
            4'd1: return {1'b0, a} - {1'b0, b};
            4'd2: return {1'b0, a & b};
            4'd3: return {1'b0, a | b};
            4'd4: return {1'b0, a ^ b};
            4'd5: return {1'b0, ~a};
            4'd6: return {a, 1'b0};
            4'd7: return {a[0], 1'b0, a[15:1]};
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] ref_flag(input logic [16:0] r);
        return {r[16], (r[15:0] == 16'h0000)};
    endfunction

    always_comb begin
        alu_res  = ref_alu(alu_a, alu_b, alu_op);
        alu_flag = ref_flag(alu_res);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transaction model: what the architectural state must be, plus whether a
    // request is in flight (waiting for the ALU) or a result is being offered.
    logic [15:0] m_acc, m_b;
    logic [3:0]  m_op;
    logic [1:0]  m_flags;
    logic        m_err, m_live, m_exec, m_valid;
    logic [16:0] m_r;

    assign m_r = ref_alu(m_acc, m_b, m_op);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc <= '0; m_b <= '0; m_op <= '0; m_flags <= '0;
            m_err <= 1'b0; m_live <= 1'b0; m_exec <= 1'b0; m_valid <= 1'b0;
        end else begin
            m_live <= 1'b1;
            if (m_live && !m_exec && !m_valid && in_valid) begin
                if (in_load) begin
                    m_acc <= in_operand; m_err <= 1'b0; m_valid <= 1'b1;
                end else if (in_op > 4'd7) begin
                    m_err <= 1'b1; m_valid <= 1'b1;
                end else begin
                    m_b <= in_operand; m_op <= in_op; m_err <= 1'b0; m_exec <= 1'b1;
                end
            end else if (m_exec) begin
                m_acc   <= m_r[15:0];
                m_flags <= ref_flag(m_r);
                m_exec  <= 1'b0;
                m_valid <= 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_live && !m_exec && !m_valid);
        chk("out_valid", out_valid, m_valid);
        chk("out_err", out_err, m_err);
        chk("alu_a", alu_a, m_acc);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", alu_op, m_op);
        if (m_valid) begin
            chk("out_data", out_data, m_acc);
            chk("out_flag", out_flag, m_flags);
        end
    end

    // Issue one request (called at posedge+2), check latency and literal result.
    task automatic txn(input string name, input logic ld, input logic [3:0] op,
                       input logic [15:0] val, input int hold,
                       input int exp_lat, input logic [15:0] exp_a,
                       input logic [15:0] exp_data, input logic [1:0] exp_flag,
                       input logic exp_err);
        int n;
        bit got;
        in_valid = 1'b1; in_load = ld; in_op = op; in_operand = val;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1;
        end
        chk({name, "_accept_timeout"}, got, 1'b1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        n = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            if (n == 1 && exp_lat == 2) chk({name, "_exec_alu_a"}, alu_a, exp_a);
            if (out_valid) got = 1;
        end
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_data"}, out_data, exp_data);
        chk({name, "_flag"}, out_flag, exp_flag);
        chk({name, "_err"}, out_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, out_valid, 1'b1);
            chk({name, "_hold_data"}, out_data, exp_data);
            chk({name, "_hold_flag"}, out_flag, exp_flag);
            chk({name, "_hold_ready"}, in_ready, 1'b0);
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Reset in the middle of an ALU operation.
        txn("pre_load", 1'b1, 4'd0, 16'h1234, 0, 1, 16'h0, 16'h1234, 2'b00, 1'b0);
        in_valid = 1'b1; in_load = 1'b0; in_op = 4'd0; in_operand = 16'h0001;
        @(negedge clk);
        @(posedge clk); #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_acc", alu_a, 16'h0000);
        chk("midrst_flag", out_flag, 2'b00);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_out_valid", out_valid, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_not_yet_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("release_ready", in_ready, 1'b1);
        chk("release_no_result", out_valid, 1'b0);
        @(posedge clk); #2;

        txn("load5", 1'b1, 4'd0, 16'h0005, 0, 1, 16'h0, 16'h0005, 2'b00, 1'b0);
        txn("add3", 1'b0, 4'd0, 16'h0003, 0, 2, 16'h0005, 16'h0008, 2'b00, 1'b0);
        txn("loadffff", 1'b1, 4'd0, 16'hFFFF, 0, 1, 16'h0, 16'hFFFF, 2'b00, 1'b0);
        txn("add1_wrap", 1'b0, 4'd0, 16'h0001, 0, 2, 16'hFFFF, 16'h0000, 2'b11, 1'b0);

        // Backpressure with the next request already held valid.
        txn("bp_load", 1'b1, 4'd0, 16'h0042, 0, 1, 16'h0, 16'h0042, 2'b11, 1'b0);
        in_valid = 1'b1; in_load = 1'b0; in_op = 4'd2; in_operand = 16'h00F0;
        @(negedge clk);
        @(posedge clk); #2;
        for (int i = 0; i < 2; i++) @(negedge clk);
        chk("bp_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_data", out_data, 16'h0040);
            chk("bp_hold_flag", out_flag, 2'b00);
            chk("bp_hold_ready", in_ready, 1'b0);
        end
        @(posedge clk); #2;
        in_load = 1'b1; in_operand = 16'h0010;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_ready", in_ready, 1'b1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_held_accepted", out_valid, 1'b1);
        chk("bp_held_data", out_data, 16'h0010);
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;

        // Illegal opcode, then a legal op clears the error.
        txn("illegal12", 1'b0, 4'd12, 16'h7777, 0, 1, 16'h0, 16'h0010, 2'b00, 1'b1);
        txn("add0", 1'b0, 4'd0, 16'h0000, 0, 2, 16'h0010, 16'h0010, 2'b00, 1'b0);

        // Chained operations reuse the accumulator.
        txn("chain_load", 1'b1, 4'd0, 16'h000A, 0, 1, 16'h0, 16'h000A, 2'b00, 1'b0);
        txn("chain_sub", 1'b0, 4'd1, 16'h0003, 2, 2, 16'h000A, 16'h0007, 2'b00, 1'b0);
        txn("chain_add", 1'b0, 4'd0, 16'h0002, 0, 2, 16'h0007, 16'h0009, 2'b00, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            in_valid   = ($urandom_range(0, 9) < 7);
            in_load    = ($urandom_range(0, 3) == 0);
            in_op      = 4'($urandom_range(0, 9));
            in_operand = 16'($urandom);
            out_ready  = ($urandom_range(0, 9) < 6);
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
